// File: rtl/autoconfig_master_pkg.sv
// autoconfig_master_pkg: shared register offsets, region limits, size decode and state types for the Zorro II AutoConfig initiator
package autoconfig_master_pkg;
  localparam logic [7:0] CFG_SPACE   = 8'hE8;
  localparam logic [7:0] REG_TYPE    = 8'h00;
  localparam logic [7:0] REG_SIZE    = 8'h01;
  localparam logic [7:0] REG_PROD    = 8'h02;
  localparam logic [7:0] REG_MFG     = 8'h08;
  localparam logic [7:0] REG_BASE_HI = 8'h24;
  localparam logic [7:0] REG_BASE_LO = 8'h25;
  localparam logic [7:0] REG_SHUTUP  = 8'h26;
  localparam logic [8:0] MEM_FIRST   = 9'h020;
  localparam logic [8:0] MEM_LIMIT   = 9'h0A0;
  localparam logic [8:0] IO_FIRST    = 9'h0E9;
  localparam logic [8:0] IO_LIMIT    = 9'h0F0;
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DECIDE, S_WR_LO, S_WR_HI, S_SHUTUP, S_NEXT, S_FINISH
  } state_t;
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_STROBE, B_GAP} bus_state_t;
  function automatic logic [7:0] read_reg(input logic [2:0] idx);
    return idx == 3'd0 ? REG_TYPE :
           idx == 3'd1 ? REG_SIZE :
           idx[2]      ? REG_MFG + {6'd0, idx[1:0]} :
                         REG_PROD + {7'd0, idx[0]};
  endfunction
  function automatic logic [8:0] size_units(input logic [2:0] code);
    return code == 3'd0 ? 9'd128 : 9'd1 << (code - 3'd1);
  endfunction
endpackage

// File: rtl/autoconfig_master_bus_cycle.sv
// z2_bus_cycle: one Zorro II strobe/ack/timeout transaction (start_i/reg_i/rw_i/wdata_i in, ADDR/AS_n/RW/DOUT pins out, DIN/DTACK in, done_o/timeout_o/rdata_o back)
module z2_bus_cycle
  import autoconfig_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  reg_i,
  input  logic        rw_i,
  input  logic [3:0]  wdata_i,
  output logic [22:0] addr_o,
  output logic        as_n_o,
  output logic        rw_o,
  output logic [3:0]  dout_o,
  input  logic [3:0]  din_i,
  input  logic        dtack_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [3:0]  rdata_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  bus_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic as_n_q, as_n_d, rw_q, rw_d, done_q, done_d, timeout_q, timeout_d;
  logic [3:0] dout_q, dout_d, rdata_q, rdata_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    as_n_d    = as_n_q;
    rw_d      = rw_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      B_IDLE: if (start_i) begin
        addr_d  = {CFG_SPACE, 7'h0, reg_i};
        rw_d    = rw_i;
        dout_d  = wdata_i;
        state_d = B_SETUP;
      end
      B_SETUP: begin
        as_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = B_STROBE;
      end
      B_STROBE: if (dtack_i) begin
        rdata_d = din_i;
        as_n_d  = 1'b1;
        cnt_d   = '0;
        state_d = B_GAP;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        as_n_d    = 1'b1;
        timeout_d = 1'b1;
        state_d   = B_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      B_GAP: begin
        cnt_d   = cnt_q + 1'b1;
        done_d  = cnt_q == CW'(1);
        state_d = cnt_q == CW'(1) ? B_IDLE : B_GAP;
      end
      default: state_d = B_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= B_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      as_n_q    <= 1'b1;
      rw_q      <= 1'b1;
      dout_q    <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      as_n_q    <= as_n_d;
      rw_q      <= rw_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end
  assign addr_o    = addr_q;
  assign as_n_o    = as_n_q;
  assign rw_o      = rw_q;
  assign dout_o    = dout_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign rdata_o   = rdata_q;
endmodule

// File: rtl/autoconfig_master.sv
// autoconfig_master: Zorro II AutoConfig scan engine (START in; bus pins ADDR/AS_n/RW/DOUT/DIN/DTACK; BUSY/DONE/ERROR/BOARD_COUNT status; CFG_* per-board report)
module autoconfig_master
  import autoconfig_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_BOARDS     = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        DTACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [3:0]  BOARD_COUNT,
  output logic        CFG_VALID,
  output logic [15:0] CFG_MFG,
  output logic [7:0]  CFG_PROD,
  output logic [7:0]  CFG_BASE,
  output logic        CFG_IO,
  output logic        CFG_SHUTUP
);
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, typ_q, typ_d, size_q, size_d;
  logic [23:0] id_q, id_d;
  logic [7:0] base_q, base_d, prod_q, prod_d, cbase_q, cbase_d;
  logic [15:0] mfg_q, mfg_d;
  logic [8:0] mem_ptr_q, mem_ptr_d, io_ptr_q, io_ptr_d;
  logic [3:0] count_q, count_d;
  logic shut_q, shut_d, pend_q, pend_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic valid_q, valid_d, cio_q, cio_d, cshut_q, cshut_d;
  logic bus_start, bus_rw, bus_done, bus_timeout;
  logic [7:0] bus_reg;
  logic [3:0] bus_wdata, bus_rdata;
  logic zorro, is_ram, fits;
  logic [8:0] sz, mask, new_base, new_end;
  assign zorro    = typ_q[2:1] == 2'b11;
  assign is_ram   = typ_q[0];
  assign sz       = size_units(size_q);
  assign mask     = sz - 9'd1;
  // RAM aligns relative to the region start, IO aligns on absolute address
  assign new_base = is_ram ? MEM_FIRST + ((mem_ptr_q - MEM_FIRST + mask) & ~mask) : (io_ptr_q + mask) & ~mask;
  assign new_end  = new_base + sz;
  assign fits     = zorro && new_end <= (is_ram ? MEM_LIMIT : IO_LIMIT);
  assign bus_start = !pend_q && (state_q == S_READ || state_q == S_WR_LO || state_q == S_WR_HI || state_q == S_SHUTUP);
  assign bus_rw    = state_q == S_READ;
  assign bus_reg   = state_q == S_WR_LO ? REG_BASE_LO : state_q == S_WR_HI ? REG_BASE_HI :
                     state_q == S_SHUTUP ? REG_SHUTUP : read_reg(idx_q);
  assign bus_wdata = state_q == S_WR_LO ? base_q[3:0] : state_q == S_WR_HI ? base_q[7:4] : 4'h0;
  z2_bus_cycle #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_bus (
    .clk(CLK), .rst(RESET), .start_i(bus_start), .reg_i(bus_reg), .rw_i(bus_rw), .wdata_i(bus_wdata),
    .addr_o(ADDR), .as_n_o(AS_n), .rw_o(RW), .dout_o(DOUT), .din_i(DIN), .dtack_i(DTACK),
    .done_o(bus_done), .timeout_o(bus_timeout), .rdata_o(bus_rdata)
  );
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    typ_d     = typ_q;
    size_d    = size_q;
    id_d      = id_q;
    base_d    = base_q;
    shut_d    = shut_q;
    mem_ptr_d = mem_ptr_q;
    io_ptr_d  = io_ptr_q;
    count_d   = count_q;
    busy_d    = busy_q;
    error_d   = error_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    mfg_d     = mfg_q;
    prod_d    = prod_q;
    cbase_d   = cbase_q;
    cio_d     = cio_q;
    cshut_d   = cshut_q;
    pend_d    = bus_start ? 1'b1 : (bus_done || bus_timeout) ? 1'b0 : pend_q;
    case (state_q)
      S_IDLE: if (START) begin
        error_d   = 1'b0;
        count_d   = '0;
        mem_ptr_d = MEM_FIRST;
        io_ptr_d  = IO_FIRST;
        busy_d    = 1'b1;
        idx_d     = '0;
        state_d   = S_READ;
      end
      S_READ: if (bus_timeout) begin
        // a silent type read just means the chain is exhausted
        error_d = idx_q != 3'd0;
        state_d = S_FINISH;
      end else if (bus_done) begin
        typ_d   = idx_q == 3'd0 ? bus_rdata[3:1] : typ_q;
        size_d  = idx_q == 3'd1 ? bus_rdata[2:0] : size_q;
        // product then manufacturer nibbles arrive MSB first and are stored inverted
        id_d    = idx_q[2:1] != 2'b00 ? {id_q[19:0], ~bus_rdata} : id_q;
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? S_DECIDE : S_READ;
      end
      S_DECIDE: begin
        shut_d    = !fits;
        base_d    = fits ? new_base[7:0] : 8'h00;
        mem_ptr_d = fits && is_ram ? new_end : mem_ptr_q;
        io_ptr_d  = fits && !is_ram ? new_end : io_ptr_q;
        state_d   = fits ? S_WR_LO : S_SHUTUP;
      end
      S_WR_LO, S_WR_HI, S_SHUTUP: if (bus_timeout) begin
        error_d = 1'b1;
        state_d = S_FINISH;
      end else if (bus_done) begin
        state_d = state_q == S_WR_LO ? S_WR_HI : S_NEXT;
      end
      S_NEXT: begin
        valid_d = 1'b1;
        mfg_d   = id_q[15:0];
        prod_d  = id_q[23:16];
        cbase_d = base_q;
        cio_d   = !is_ram;
        cshut_d = shut_q;
        count_d = count_q + 4'd1;
        state_d = count_d == 4'(MAX_BOARDS) ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      typ_q     <= '0;
      size_q    <= '0;
      id_q      <= '0;
      base_q    <= '0;
      shut_q    <= 1'b0;
      mem_ptr_q <= MEM_FIRST;
      io_ptr_q  <= IO_FIRST;
      count_q   <= '0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      mfg_q     <= '0;
      prod_q    <= '0;
      cbase_q   <= '0;
      cio_q     <= 1'b0;
      cshut_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      typ_q     <= typ_d;
      size_q    <= size_d;
      id_q      <= id_d;
      base_q    <= base_d;
      shut_q    <= shut_d;
      mem_ptr_q <= mem_ptr_d;
      io_ptr_q  <= io_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      mfg_q     <= mfg_d;
      prod_q    <= prod_d;
      cbase_q   <= cbase_d;
      cio_q     <= cio_d;
      cshut_q   <= cshut_d;
      pend_q    <= pend_d;
    end
  end
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;
  assign BOARD_COUNT = count_q;
  assign CFG_VALID   = valid_q;
  assign CFG_MFG     = mfg_q;
  assign CFG_PROD    = prod_q;
  assign CFG_BASE    = cbase_q;
  assign CFG_IO      = cio_q;
  assign CFG_SHUTUP  = cshut_q;
endmodule
